// File: rtl/min_sad_tracker_pkg.sv
// Shared widths and FSM encoding for the minimum-SAD tracker and its helpers.
package min_sad_tracker_pkg;

    localparam int SAD_W_DEF   = 12;
    localparam int COORD_W_DEF = 8;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/sad_min_cmp.sv
// Replace flag for a running-minimum search: strict less-than so ties keep the earlier candidate.
module sad_min_cmp
    import min_sad_tracker_pkg::*;
#(
    parameter int SAD_W = SAD_W_DEF
) (
    input  logic [SAD_W-1:0] cand_sad,
    input  logic [SAD_W-1:0] best_sad,
    output logic             replace
);

    assign replace = (cand_sad < best_sad);

endmodule

// File: rtl/min_sad_tracker.sv
// Tracks the minimum SAD (and its position) over a first-to-last beat search and
// presents the result with a valid/ready handshake.
module min_sad_tracker
    import min_sad_tracker_pkg::*;
#(
    parameter int SAD_W   = SAD_W_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic [SAD_W-1:0]   SADVal,
    input  logic [COORD_W-1:0] PosX,
    input  logic [COORD_W-1:0] PosY,
    input  logic               InFirst,
    input  logic               InLast,
    output logic               BestValid,
    input  logic               BestReady,
    output logic [SAD_W-1:0]   BestSAD,
    output logic [COORD_W-1:0] BestX,
    output logic [COORD_W-1:0] BestY,
    output logic [CNT_W-1:0]   CandCount,
    output logic               Orphan
);

    state_t state, next_state;
    logic   accept;
    logic   load;
    logic   update;
    logic   orphan_set;
    logic   replace;

    sad_min_cmp #(.SAD_W(SAD_W)) u_cmp (
        .cand_sad (SADVal),
        .best_sad (BestSAD),
        .replace  (replace)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        update     = 1'b0;
        orphan_set = 1'b0;
        InReady    = (state != HOLD);
        BestValid  = (state == HOLD);
        accept     = InValid && InReady;
        case (state)
            IDLE, SCAN: begin
                if (accept) begin
                    // InFirst always restarts; a non-first beat is only meaningful mid-search
                    if (InFirst) begin
                        load       = 1'b1;
                        next_state = InLast ? HOLD : SCAN;
                    end else if (state == SCAN) begin
                        update     = 1'b1;
                        next_state = InLast ? HOLD : SCAN;
                    end else begin
                        orphan_set = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (BestReady) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            BestSAD   <= '1;
            BestX     <= '0;
            BestY     <= '0;
            CandCount <= '0;
            Orphan    <= 1'b0;
        end else begin
            Orphan <= orphan_set;
            if (load) begin
                BestSAD   <= SADVal;
                BestX     <= PosX;
                BestY     <= PosY;
                CandCount <= CNT_W'(1);
            end else if (update) begin
                if (replace) begin
                    BestSAD <= SADVal;
                    BestX   <= PosX;
                    BestY   <= PosY;
                end
                if (CandCount != '1) begin
                    CandCount <= CandCount + CNT_W'(1);
                end
            end
        end
    end

endmodule
